// File: rtl/cmp_share_pkg.sv
// Shared types and helpers for the shared equality comparator arbiter.
// Holds the FSM state encoding and the round-robin winner picker.
package cmp_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } cmp_state_t;

    // Upper bound on requesters the picker can scan.
    localparam int unsigned RR_MAX = 32;
    localparam int unsigned RR_IW  = 5;

    // Winner is the first valid index after ptr, wrapping mod nreq.
    // Scanning from the far end keeps the nearest valid index last.
    function automatic int unsigned rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int unsigned       ptr,
        input int unsigned       nreq
    );
        int unsigned idx;
        rr_pick = 0;
        for (int unsigned k = RR_MAX; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (ptr + k) % nreq;
                if (valid[idx[RR_IW-1:0]]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/eq_compare.sv
// Purely combinational NBITS-wide equality comparator.
// Unsigned bitwise equality over the full operand width.
module eq_compare #(
    parameter int NBITS = 16
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one equality comparator among requesters.
// Three-cycle IDLE/CMP/RESP sequence with saturating statistics.
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter  int NBITS = 16,
    parameter  int NREQ  = 4,
    parameter  int CNTW  = 16,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*NBITS-1:0] req_a,
    input  logic [NREQ*NBITS-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_match,
    output logic                  busy,
    output logic [CNTW-1:0]       cmp_count,
    output logic [CNTW-1:0]       match_count
);

    localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

    cmp_state_t        state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NBITS-1:0]  op_a_q, op_a_d;
    logic [NBITS-1:0]  op_b_q, op_b_d;
    logic [IDW-1:0]    id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic              rsp_match_q, rsp_match_d;
    logic [CNTW-1:0]   cmp_count_q, cmp_count_d;
    logic [CNTW-1:0]   match_count_q, match_count_d;

    logic [RR_MAX-1:0] valid_ext;
    logic [IDW-1:0]    win_idx;
    logic              any_valid;
    logic              ops_eq;

    eq_compare #(
        .NBITS(NBITS)
    ) u_eq (
        .a (op_a_q),
        .b (op_b_q),
        .eq(ops_eq)
    );

    // Round-robin winner among the currently valid requesters.
    always_comb begin
        valid_ext = '0;
        valid_ext[NREQ-1:0] = req_valid;
        any_valid = |req_valid;
        win_idx = IDW'(rr_pick(valid_ext, 32'(rr_ptr_q), NREQ));
    end

    // Next-state, grant and datapath updates for the sequencer.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        id_d          = id_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_match_d   = rsp_match_q;
        cmp_count_d   = cmp_count_q;
        match_count_d = match_count_q;
        req_ready     = '0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready[win_idx] = 1'b1;
                    op_a_d  = req_a[win_idx*NBITS +: NBITS];
                    op_b_d  = req_b[win_idx*NBITS +: NBITS];
                    id_d    = win_idx;
                    state_d = CMP;
                end
            end
            CMP: begin
                rsp_match_d = ops_eq;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = id_q;
                    if (cmp_count_q != '1) begin
                        cmp_count_d = cmp_count_q + 1'b1;
                    end
                    if (rsp_match_q && match_count_q != '1) begin
                        match_count_d = match_count_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, response and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= PTR_RST;
            op_a_q        <= '0;
            op_b_q        <= '0;
            id_q          <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_match_q   <= 1'b0;
            cmp_count_q   <= '0;
            match_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            id_q          <= id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_match_q   <= rsp_match_d;
            cmp_count_q   <= cmp_count_d;
            match_count_q <= match_count_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_match   = rsp_match_q;
    assign busy        = (state_q != IDLE);
    assign cmp_count   = cmp_count_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter with directed vectors.
// A second instance with 4-bit counters exercises saturation.
module tb_cmp_share_arbiter;

    localparam int NB = 16;
    localparam int NR = 4;

    typedef struct packed {
        logic [1:0] id;
        logic       match;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [NR*NB-1:0] req_a, req_b;
    logic [NB-1:0] a_v [NR];
    logic [NB-1:0] b_v [NR];
    logic          rsp_ready;

    logic [NR-1:0] req_ready, req_ready4;
    logic          rsp_valid, rsp_valid4;
    logic [1:0]    rsp_id, rsp_id4;
    logic          rsp_match, rsp_match4;
    logic          busy, busy4;
    logic [15:0]   cmp_count, match_count;
    logic [3:0]    cmp_count4, match_count4;

    int   nasserts = 0;
    int   nfail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_a[i*NB +: NB] = a_v[i];
            req_b[i*NB +: NB] = b_v[i];
        end
    end

    cmp_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_match(rsp_match), .busy(busy),
        .cmp_count(cmp_count), .match_count(match_count)
    );

    cmp_share_arbiter #(.CNTW(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready4), .rsp_valid(rsp_valid4),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id4),
        .rsp_match(rsp_match4), .busy(busy4),
        .cmp_count(cmp_count4), .match_count(match_count4)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nasserts++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one-hot grant check and scoreboard pop per handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("onehot", 32'($onehot0(req_ready)), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    nasserts++;
                    nfail++;
                    $display("FAIL unexpected_rsp: got id %0d expected none",
                             rsp_id);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_match", 32'(rsp_match), 32'(e.match));
                end
            end
        end
    end

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input logic [NR-1:0] v,
                          input logic [1:0] id,
                          input logic m);
        exp_t e;
        @(posedge clk); #1;
        req_valid = v;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(4'b0001 << id));
        e.id = id;
        e.match = m;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
    endtask

    task automatic chk_counts(input int c, input int m);
        chk("cmp_count", 32'(cmp_count), 32'(c));
        chk("match_count", 32'(match_count), 32'(m));
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk_counts(0, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: single request, latency two cycles after accept
        a_v[0] = 16'hA5A5;
        b_v[0] = 16'hA5A5;
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h1);
        e.id = 2'd0;
        e.match = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("t1_cmp_valid", 32'(rsp_valid), 32'd0);
        chk("t1_cmp_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_resp_valid", 32'(rsp_valid), 32'd1);
        wait_idle();
        chk_counts(1, 1);

        // 2: MSB-only difference
        a_v[1] = 16'h8000;
        b_v[1] = 16'h0000;
        do_req(4'b0010, 2'd1, 1'b0);
        chk_counts(2, 1);

        // 3: all valid from reset, grants every third cycle
        @(posedge clk); #1;
        reset = 1'b1;
        #1 reset = 1'b0;
        a_v[0] = 16'h1111; b_v[0] = 16'h1111;
        a_v[1] = 16'h2222; b_v[1] = 16'h2223;
        a_v[2] = 16'h0F0F; b_v[2] = 16'h0F0F;
        a_v[3] = 16'hFFFF; b_v[3] = 16'h7FFF;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c % 3 == 0) begin
                chk("t3_grant", 32'(req_ready),
                    32'(1 << ((c / 3) % 4)));
                chk("t3_busy_idle", 32'(busy), 32'd0);
                e.id = 2'((c / 3) % 4);
                e.match = (((c / 3) % 2) == 0);
                sb.push_back(e);
            end else begin
                chk("t3_nogrant", 32'(req_ready), 32'd0);
                chk("t3_busy", 32'(busy), 32'd1);
            end
            @(posedge clk);
        end
        #1 req_valid = '0;
        wait_idle();
        chk_counts(6, 3);

        // 4: backpressure hold, operand change after accept
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t4_ready", 32'(req_ready), 32'h4);
        e.id = 2'd2;
        e.match = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 4'b1011;
        a_v[2] = 16'h1234;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_valid", 32'(rsp_valid), 32'd1);
            chk("t4_id", 32'(rsp_id), 32'd2);
            chk("t4_match", 32'(rsp_match), 32'd1);
            chk("t4_ready0", 32'(req_ready), 32'd0);
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        wait_idle();
        chk_counts(7, 4);

        // 5: asynchronous reset in CMP
        a_v[0] = 16'hA5A5;
        b_v[0] = 16'hA5A5;
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t5_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        chk("t5_in_cmp", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk_counts(0, 0);
        chk("t5_cnt4", 32'(cmp_count4), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        a_v[1] = 16'h5555;
        b_v[1] = 16'h5555;
        do_req(4'b1010, 2'd1, 1'b1);
        chk_counts(1, 1);

        // 6: saturation on the 4-bit counter instance
        for (int i = 0; i < 20; i++) begin
            do_req(4'b0001, 2'd0, 1'b1);
        end
        chk_counts(21, 21);
        chk("t6_cmp4", 32'(cmp_count4), 32'hF);
        chk("t6_match4", 32'(match_count4), 32'hF);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasserts, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
